uart_echo_ctrl: RTL and testbench

- Host-side consumer/producer for the rs232_uart buffer interface in the loopback system.
- Drains received bytes from the UART RX FIFO and writes them back into the UART TX FIFO.
- Optional lower-to-upper case conversion; optional CR to CR,LF expansion.
- Strict one-pop / one-write pacing so the FIFO status flags are always settled before they are sampled.

---
 rtl/uart_echo_ctrl_pkg.sv | 12 +
 rtl/uart_echo_ctrl_if.sv | 17 +
 rtl/uart_echo_ctrl.sv | 83 ++++++++
 tb/tb_uart_echo_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_ctrl_pkg.sv
// uart_pkg: shared FSM encoding, ASCII constants and case conversion for the echo controller
package uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, SETTLE, CHECK, WR, CHECK_LF, WR_LF} state_t;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= ASCII_LC_A && b <= ASCII_LC_Z) ? b - CASE_OFFSET : b;
  endfunction
endpackage

// File: rtl/uart_echo_ctrl_if.sv
// uart_echo_ctrl_if: rs232_uart buffer-side RX/TX FIFO handshake bundle
interface uart_echo_ctrl_if;
  logic [7:0] rx_data_out;
  logic       rx_data_present;
  logic       read_rx_data_ack;
  logic [7:0] tx_data_in;
  logic       write_tx_data;
  logic       tx_buffer_full;
  modport master (
    input  rx_data_out, rx_data_present, tx_buffer_full,
    output read_rx_data_ack, tx_data_in, write_tx_data
  );
  modport slave (
    output rx_data_out, rx_data_present, tx_buffer_full,
    input  read_rx_data_ack, tx_data_in, write_tx_data
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: drains the UART RX FIFO and echoes each byte into the TX FIFO
module uart_echo_ctrl
  import uart_pkg::*;
#(
  parameter bit UPCASE      = 1'b0,
  parameter bit CRLF_EXPAND = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  uart_echo_ctrl_if.master     bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] byte_count
);
  state_t               r_state;
  logic [7:0]           r_hold;
  logic [7:0]           r_tx_data;
  logic                 r_ack;
  logic                 r_wr;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_count;
  logic [7:0]           w_rx_byte;
  assign w_rx_byte            = UPCASE ? to_upper(bus.rx_data_out) : bus.rx_data_out;
  assign bus.read_rx_data_ack = r_ack;
  assign bus.write_tx_data    = r_wr;
  assign bus.tx_data_in       = r_tx_data;
  assign busy                 = r_busy;
  assign byte_count           = r_count;
  // Echo FSM: strobes and data are set on the transition into their state, so every output is a flop
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_hold    <= 8'h00;
      r_tx_data <= 8'h00;
      r_ack     <= 1'b0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_wr  <= 1'b0;
      case (r_state)
        IDLE:
          if (enable && bus.rx_data_present) begin
            r_hold  <= w_rx_byte;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= POP;
          end
        POP:    r_state <= SETTLE;
        SETTLE: r_state <= CHECK;
        CHECK:
          if (!bus.tx_buffer_full) begin
            r_tx_data <= r_hold;
            r_wr      <= 1'b1;
            r_count   <= r_count + CNT_WIDTH'(1);
            r_state   <= WR;
          end
        WR:
          if (CRLF_EXPAND && r_hold == ASCII_CR) r_state <= CHECK_LF;
          else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        CHECK_LF:
          if (!bus.tx_buffer_full) begin
            r_tx_data <= ASCII_LF;
            r_wr      <= 1'b1;
            r_count   <= r_count + CNT_WIDTH'(1);
            r_state   <= WR_LF;
          end
        WR_LF: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb_uart_echo_ctrl: scoreboard bench with FIFO models for two parameterisations of the echo controller
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end end
module tb_uart_echo_ctrl;
  logic clk = 1'b0, reset = 1'b1, ena = 1'b0, enb = 1'b0;
  logic busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int tests = 0, fails = 0;
  int ack_cnt_a = 0, wr_cnt_a = 0;
  logic [7:0] rxa[$], rxb[$], expa[$], expb[$];
  logic [7:0] ea, eb;
  logic pend_a = 1'b0, pend_b = 1'b0, pack_a = 1'b0, pwr_a = 1'b0, pack_b = 1'b0, pwr_b = 1'b0;
  logic [7:0] tbl [5] = '{8'h61, 8'h7A, 8'h60, 8'h7B, 8'h0D};
  uart_echo_ctrl_if ifa ();
  uart_echo_ctrl_if ifb ();
  uart_echo_ctrl #(.UPCASE(1'b0), .CRLF_EXPAND(1'b1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .enable(ena), .bus(ifa), .busy(busy_a), .byte_count(cnt_a));
  uart_echo_ctrl #(.UPCASE(1'b1), .CRLF_EXPAND(1'b0), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enb), .bus(ifb), .busy(busy_b), .byte_count(cnt_b));
  always #5 clk = ~clk;
  function automatic logic [7:0] upc(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction
  // RX FIFO models: a pop strobed in the previous cycle takes effect just after the edge
  always @(posedge clk) begin
    #1;
    if (pend_a && rxa.size() > 0) void'(rxa.pop_front());
    if (pend_b && rxb.size() > 0) void'(rxb.pop_front());
    ifa.rx_data_present = rxa.size() != 0;
    ifa.rx_data_out     = rxa.size() != 0 ? rxa[0] : 8'h00;
    ifb.rx_data_present = rxb.size() != 0;
    ifb.rx_data_out     = rxb.size() != 0 ? rxb[0] : 8'h00;
  end
  // TX monitors: scoreboard compare plus strobe exclusion / spacing checks
  always @(negedge clk) begin
    pend_a = ifa.read_rx_data_ack;
    if (ifa.read_rx_data_ack) ack_cnt_a++;
    if (ifa.read_rx_data_ack || ifa.write_tx_data) begin
      `CHK("a_excl", ifa.read_rx_data_ack & ifa.write_tx_data, 1'b0)
      `CHK("a_b2b", (ifa.read_rx_data_ack & pack_a) | (ifa.write_tx_data & pwr_a), 1'b0)
    end
    if (ifa.write_tx_data) begin
      wr_cnt_a++;
      if (expa.size() == 0) begin
        tests++; fails++;
        $error("FAIL a_unexp_wr: observed write %0h expected none", ifa.tx_data_in);
      end else begin
        ea = expa.pop_front();
        `CHK("a_tx", ifa.tx_data_in, ea)
      end
    end
    pack_a = ifa.read_rx_data_ack;
    pwr_a  = ifa.write_tx_data;
    pend_b = ifb.read_rx_data_ack;
    if (ifb.read_rx_data_ack || ifb.write_tx_data) begin
      `CHK("b_excl", ifb.read_rx_data_ack & ifb.write_tx_data, 1'b0)
      `CHK("b_b2b", (ifb.read_rx_data_ack & pack_b) | (ifb.write_tx_data & pwr_b), 1'b0)
    end
    if (ifb.write_tx_data) begin
      if (expb.size() == 0) begin
        tests++; fails++;
        $error("FAIL b_unexp_wr: observed write %0h expected none", ifb.tx_data_in);
      end else begin
        eb = expb.pop_front();
        `CHK("b_tx", ifb.tx_data_in, eb)
      end
    end
    pack_b = ifb.read_rx_data_ack;
    pwr_b  = ifb.write_tx_data;
  end
  task automatic wait_idle(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (b ? (expb.size() == 0 && !busy_b) : (expa.size() == 0 && !busy_a)) return;
    end
    tests++; fails++;
    $error("FAIL %s_idle_timeout: observed still busy after %0d cycles expected idle", b ? "b" : "a", n);
  endtask
  task automatic wait_a(input bit wr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wr ? ifa.write_tx_data : ifa.read_rx_data_ack) return;
    end
    tests++; fails++;
    $error("FAIL a_%s_timeout: observed no strobe in %0d cycles expected strobe", wr ? "wr" : "ack", n);
  endtask
  initial begin
    int a0, w0;
    logic [7:0] v;
    ifa.tx_buffer_full = 1'b0;
    ifb.tx_buffer_full = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    `CHK("rst_a_ack", ifa.read_rx_data_ack, 1'b0)
    `CHK("rst_a_wr", ifa.write_tx_data, 1'b0)
    `CHK("rst_a_tx", ifa.tx_data_in, 8'h00)
    `CHK("rst_a_busy", busy_a, 1'b0)
    `CHK("rst_a_cnt", cnt_a, 16'h0)
    `CHK("rst_b_tx", ifb.tx_data_in, 8'h00)
    `CHK("rst_b_cnt", cnt_b, 4'h0)
    @(negedge clk);
    reset = 1'b1; ena = 1'b1; enb = 1'b1;
    repeat (2) @(negedge clk);
    rxa.push_back(8'h41); expa.push_back(8'h41);
    @(posedge clk);
    @(negedge clk);
    `CHK("lat_c0_ack", ifa.read_rx_data_ack, 1'b0)
    `CHK("lat_c0_busy", busy_a, 1'b0)
    @(negedge clk);
    `CHK("lat_c1_ack", ifa.read_rx_data_ack, 1'b1)
    `CHK("lat_c1_busy", busy_a, 1'b1)
    @(negedge clk);
    `CHK("lat_c2_ack", ifa.read_rx_data_ack, 1'b0)
    `CHK("lat_c2_busy", busy_a, 1'b1)
    @(negedge clk);
    `CHK("lat_c3_wr", ifa.write_tx_data, 1'b0)
    @(negedge clk);
    `CHK("lat_c4_wr", ifa.write_tx_data, 1'b1)
    `CHK("lat_c4_busy", busy_a, 1'b1)
    @(negedge clk);
    `CHK("lat_c5_busy", busy_a, 1'b0)
    `CHK("lat_cnt", cnt_a, 16'd1)
    rxa.push_back(8'h0D); expa.push_back(8'h0D); expa.push_back(8'h0A);
    wait_a(1'b1, 20);
    `CHK("cr_data", ifa.tx_data_in, 8'h0D)
    @(negedge clk);
    `CHK("cr_gap_wr", ifa.write_tx_data, 1'b0)
    @(negedge clk);
    `CHK("lf_wr", ifa.write_tx_data, 1'b1)
    `CHK("lf_data", ifa.tx_data_in, 8'h0A)
    wait_idle(1'b0, 20);
    `CHK("crlf_cnt", cnt_a, 16'd3)
    ifa.tx_buffer_full = 1'b1;
    a0 = ack_cnt_a; w0 = wr_cnt_a;
    rxa.push_back(8'h55); expa.push_back(8'h55);
    repeat (50) @(negedge clk);
    `CHK("full_no_wr", wr_cnt_a, w0)
    `CHK("full_one_ack", ack_cnt_a, a0 + 1)
    `CHK("full_busy", busy_a, 1'b1)
    `CHK("full_tx_hold", ifa.tx_data_in, 8'h0A)
    ifa.tx_buffer_full = 1'b0;
    @(negedge clk);
    `CHK("full_release_wr", ifa.write_tx_data, 1'b1)
    `CHK("full_release_data", ifa.tx_data_in, 8'h55)
    wait_idle(1'b0, 20);
    `CHK("full_cnt", cnt_a, 16'd4)
    ifa.tx_buffer_full = 1'b1;
    rxa.push_back(8'h77);
    repeat (8) @(negedge clk);
    `CHK("pre_rst_busy", busy_a, 1'b1)
    reset = 1'b0;
    #1;
    `CHK("mid_rst_ack", ifa.read_rx_data_ack, 1'b0)
    `CHK("mid_rst_wr", ifa.write_tx_data, 1'b0)
    `CHK("mid_rst_tx", ifa.tx_data_in, 8'h00)
    `CHK("mid_rst_busy", busy_a, 1'b0)
    `CHK("mid_rst_cnt", cnt_a, 16'h0)
    @(negedge clk);
    ifa.tx_buffer_full = 1'b0;
    reset = 1'b1;
    rxa.push_back(8'h33); expa.push_back(8'h33);
    wait_idle(1'b0, 20);
    `CHK("post_rst_cnt", cnt_a, 16'd1)
    ena = 1'b0;
    a0 = ack_cnt_a;
    rxa.push_back(8'h5A);
    repeat (20) @(negedge clk);
    `CHK("dis_no_ack", ack_cnt_a, a0)
    `CHK("dis_busy", busy_a, 1'b0)
    expa.push_back(8'h5A);
    ena = 1'b1;
    wait_idle(1'b0, 20);
    `CHK("en_cnt", cnt_a, 16'd2)
    rxa.push_back(8'h0D); rxa.push_back(8'h44);
    expa.push_back(8'h0D); expa.push_back(8'h0A);
    wait_a(1'b0, 20);
    ena = 1'b0;
    repeat (20) @(negedge clk);
    `CHK("mid_dis_drained", expa.size(), 0)
    `CHK("mid_dis_rx_left", rxa.size(), 1)
    `CHK("mid_dis_cnt", cnt_a, 16'd4)
    expa.push_back(8'h44);
    ena = 1'b1;
    wait_idle(1'b0, 20);
    `CHK("mid_dis_cnt2", cnt_a, 16'd5)
    for (int i = 0; i < 17; i++) begin
      v = i < 5 ? tbl[i] : 8'($urandom_range(255));
      rxb.push_back(v);
      expb.push_back(upc(v));
    end
    wait_idle(1'b1, 300);
    `CHK("b_drained", expb.size(), 0)
    `CHK("b_cnt_wrap", cnt_b, 4'h1)
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
